// File: rtl/tc_mul_pkg.sv
// tc_mul_pkg: shared constants and types for the tensor-core lane multiplier.
//   RM_*      rounding-mode codes on rm_i (anything other than RM_SAT wraps)
//   FF_*      bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag word
//   ctrl_t    sideband bundle at the default widths (c=16, warpid=4)
//   mk_fflags builds the flag word from a single overflow indication
package tc_mul_pkg;

  localparam logic [2:0] RM_WRAP = 3'd0;
  localparam logic [2:0] RM_SAT  = 3'd1;

  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;
  localparam int NUM_FFLAGS = 5;

  localparam int CTRL_C_W   = 16;
  localparam int WARP_W     = 4;
  localparam int REG_IDXW_W = 8;

  typedef struct packed {
    logic [CTRL_C_W-1:0]   c;
    logic [2:0]            rm;
    logic [REG_IDXW_W-1:0] reg_idxw;
    logic [WARP_W-1:0]     warpid;
  } ctrl_t;

  // Integer multiply can only overflow; an out-of-range result is also inexact.
  function automatic logic [NUM_FFLAGS-1:0] mk_fflags(input logic of);
    logic [NUM_FFLAGS-1:0] f;
    f        = '0;
    f[FF_OF] = of;
    f[FF_NX] = of;
    return f;
  endfunction

endpackage

// File: rtl/tc_mul_lane.sv
// tc_mul_lane: one combinational signed multiplier lane.
//   a, b    signed EW-bit operands
//   active  lane mask bit; inactive lanes output 0 and raise no flag
//   sat     1 = clamp out-of-range products, 0 = keep the low EW bits
//   res     EW-bit result
//   of      product did not fit in EW bits (only when active)
module tc_mul_lane #(
  parameter int EW = 9
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic          active,
  input  logic          sat,
  output logic [EW-1:0] res,
  output logic          of
);

  logic signed [2*EW-1:0] a_x, b_x, prod;
  logic                   in_range;

  // Sign-extend first so the 2*EW-bit product is exact.
  assign a_x  = {{EW{a[EW-1]}}, a};
  assign b_x  = {{EW{b[EW-1]}}, b};
  assign prod = a_x * b_x;

  // Fits in EW bits iff the top EW+1 bits are all copies of the sign.
  assign in_range = (&prod[2*EW-1:EW-1]) | ~(|prod[2*EW-1:EW-1]);

  always_comb begin
    res = '0;
    of  = 1'b0;
    if (active) begin
      of = ~in_range;
      if (sat && !in_range)
        res = prod[2*EW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
      else
        res = prod[EW-1:0];
    end
  end

endmodule

// File: rtl/tc_mul_array.sv
// tc_mul_array: NUM_LANES signed multipliers behind one valid/ready handshake,
// followed by a PIPE_STAGES-deep elastic register chain.
//   a_i/b_i/lane_mask_i/rm_i   operands, lane enables, rounding mode
//   ctrl_*_i                   sideband carried alongside the beat
//   in_valid_i/in_ready_o      input handshake
//   out_valid_o/out_ready_i    output handshake
//   result_o/fflags_o/ctrl_*_o output beat, held stable while stalled
// Arithmetic happens before stage 0; later stages only move registers.
module tc_mul_array
  import tc_mul_pkg::*;
#(
  parameter int NUM_LANES     = 8,
  parameter int ELEMENT_WIDTH = 9,
  parameter int PIPE_STAGES   = 2,
  parameter int CTRL_C_WIDTH  = 16,
  parameter int DEPTH_WARP    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_LANES*ELEMENT_WIDTH-1:0] a_i,
  input  logic [NUM_LANES*ELEMENT_WIDTH-1:0] b_i,
  input  logic [NUM_LANES-1:0]               lane_mask_i,
  input  logic [2:0]                         rm_i,
  input  logic [CTRL_C_WIDTH-1:0]            ctrl_c_i,
  input  logic [2:0]                         ctrl_rm_i,
  input  logic [7:0]                         ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]              ctrl_warpid_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_LANES*ELEMENT_WIDTH-1:0] result_o,
  output logic [4:0]                         fflags_o,
  output logic [CTRL_C_WIDTH-1:0]            ctrl_c_o,
  output logic [2:0]                         ctrl_rm_o,
  output logic [7:0]                         ctrl_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]              ctrl_warpid_o
);

  localparam int EW   = ELEMENT_WIDTH;
  localparam int LAST = PIPE_STAGES - 1;

  // Sideband at this instance's widths (ctrl_t in the package is the default shape).
  typedef struct packed {
    logic [CTRL_C_WIDTH-1:0] c;
    logic [2:0]              rm;
    logic [7:0]              reg_idxw;
    logic [DEPTH_WARP-1:0]   warpid;
  } sb_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][EW-1:0] res;
    logic [NUM_FFLAGS-1:0]        fflags;
    sb_t                          ctrl;
  } beat_t;

  logic [NUM_LANES-1:0][EW-1:0] lane_res;
  logic [NUM_LANES-1:0]         lane_of;
  logic                         sat;
  beat_t                        s0_d;
  beat_t [PIPE_STAGES-1:0]      pipe_q;
  logic  [PIPE_STAGES-1:0]      vld_pipe;
  logic  [PIPE_STAGES-1:0]      load;

  assign sat = (rm_i == RM_SAT);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tc_mul_lane #(.EW(EW)) u_lane (
      .a      (a_i[i*EW +: EW]),
      .b      (b_i[i*EW +: EW]),
      .active (lane_mask_i[i]),
      .sat    (sat),
      .res    (lane_res[i]),
      .of     (lane_of[i])
    );
  end

  always_comb begin
    s0_d             = '0;
    s0_d.res         = lane_res;
    s0_d.fflags      = mk_fflags(|lane_of);
    s0_d.ctrl.c        = ctrl_c_i;
    s0_d.ctrl.rm       = ctrl_rm_i;
    s0_d.ctrl.reg_idxw = ctrl_reg_idxw_i;
    s0_d.ctrl.warpid   = ctrl_warpid_i;
  end

  // A stage can load if it is empty or everything downstream of it can move:
  // load[s] = out_ready | any empty stage at or after s. Walking from the
  // output back keeps the chain acyclic and lets bubbles collapse.
  always_comb begin : p_load
    logic hole;
    hole = out_ready_i;
    load = '0;
    for (int s = LAST; s >= 0; s--) begin
      hole    = hole | ~vld_pipe[s];
      load[s] = hole;
    end
  end

  assign in_ready_o = load[0];

  // Payload loads whenever the stage opens, so a stalled last stage never
  // changes and the output holds stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      pipe_q   <= '0;
    end else begin
      if (load[0]) begin
        vld_pipe[0] <= in_valid_i;
        pipe_q[0]   <= s0_d;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (load[s]) begin
          vld_pipe[s] <= vld_pipe[s-1];
          pipe_q[s]   <= pipe_q[s-1];
        end
      end
    end
  end

  assign out_valid_o     = vld_pipe[LAST];
  assign result_o        = pipe_q[LAST].res;
  assign fflags_o        = pipe_q[LAST].fflags;
  assign ctrl_c_o        = pipe_q[LAST].ctrl.c;
  assign ctrl_rm_o       = pipe_q[LAST].ctrl.rm;
  assign ctrl_reg_idxw_o = pipe_q[LAST].ctrl.reg_idxw;
  assign ctrl_warpid_o   = pipe_q[LAST].ctrl.warpid;

endmodule

// File: tb/tb_tc_mul_array.sv
// tb_tc_mul_array: directed and random checks of tc_mul_array against an
// integer-arithmetic reference model and an in-order expected-beat queue.
module tb_tc_mul_array;
  import tc_mul_pkg::*;

  localparam int NL = 8;
  localparam int EW = 9;
  localparam int PS = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NL*EW-1:0]    a_i, b_i;
  logic [NL-1:0]       lane_mask_i;
  logic [2:0]          rm_i;
  logic [15:0]         ctrl_c_i;
  logic [2:0]          ctrl_rm_i;
  logic [7:0]          ctrl_reg_idxw_i;
  logic [3:0]          ctrl_warpid_i;
  logic                in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [NL*EW-1:0]    result_o;
  logic [4:0]          fflags_o;
  logic [15:0]         ctrl_c_o;
  logic [2:0]          ctrl_rm_o;
  logic [7:0]          ctrl_reg_idxw_o;
  logic [3:0]          ctrl_warpid_o;

  tc_mul_array #(.NUM_LANES(NL), .ELEMENT_WIDTH(EW), .PIPE_STAGES(PS),
                 .CTRL_C_WIDTH(16), .DEPTH_WARP(4)) dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .lane_mask_i(lane_mask_i),
    .rm_i(rm_i), .ctrl_c_i(ctrl_c_i), .ctrl_rm_i(ctrl_rm_i),
    .ctrl_reg_idxw_i(ctrl_reg_idxw_i), .ctrl_warpid_i(ctrl_warpid_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .fflags_o(fflags_o), .ctrl_c_o(ctrl_c_o),
    .ctrl_rm_o(ctrl_rm_o), .ctrl_reg_idxw_o(ctrl_reg_idxw_o),
    .ctrl_warpid_o(ctrl_warpid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0][EW-1:0] a, b;
    logic [NL-1:0]         mask;
    logic [2:0]            rm;
    ctrl_t                 ctrl;
  } beat_t;

  typedef struct packed {
    logic [NL*EW-1:0] res;
    logic [4:0]       ff;
    ctrl_t            ctrl;
  } exp_t;

  exp_t        q[$];
  int          emitted_c[$];
  beat_t       cur;
  int          total = 0, passed = 0;
  int          cyc = 0, acc_n = 0, emit_n = 0, acc_cyc = 0, emit_cyc = 0;
  logic [NL*EW-1:0] last_res;
  logic [4:0]       last_ff;
  ctrl_t            last_ctrl;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: exact integer product, then the range/rounding rules.
  function automatic exp_t model(input beat_t bt);
    exp_t e;
    int   ai, bi, p;
    bit   any_of;
    e      = '0;
    any_of = 0;
    for (int i = 0; i < NL; i++) begin
      ai = $signed(bt.a[i]);
      bi = $signed(bt.b[i]);
      p  = ai * bi;
      if (bt.mask[i]) begin
        if (p > 255 || p < -256) begin
          any_of = 1;
          if (bt.rm == 3'd1) p = (p > 0) ? 255 : -256;
        end
        e.res[i*EW +: EW] = p[EW-1:0];
      end
    end
    e.ff   = any_of ? 5'b00101 : 5'b00000;
    e.ctrl = bt.ctrl;
    return e;
  endfunction

  function automatic beat_t zero_beat();
    beat_t bt;
    bt.a = '0; bt.b = '0; bt.mask = '1; bt.rm = 3'd0; bt.ctrl = '0;
    return bt;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    for (int i = 0; i < NL; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bt.a[i] = 9'($urandom);
        bt.b[i] = 9'($urandom);
      end else begin
        bt.a[i] = 9'($urandom_range(0, 40) - 20);
        bt.b[i] = 9'($urandom_range(0, 40) - 20);
      end
    end
    bt.mask          = 8'($urandom);
    bt.rm            = 3'($urandom_range(0, 7));
    bt.ctrl.c        = 16'($urandom);
    bt.ctrl.rm       = 3'($urandom);
    bt.ctrl.reg_idxw = 8'($urandom);
    bt.ctrl.warpid   = 4'($urandom);
    return bt;
  endfunction

  task automatic set_in(input beat_t bt, input logic v);
    cur             = bt;
    a_i             = bt.a;
    b_i             = bt.b;
    lane_mask_i     = bt.mask;
    rm_i            = bt.rm;
    ctrl_c_i        = bt.ctrl.c;
    ctrl_rm_i       = bt.ctrl.rm;
    ctrl_reg_idxw_i = bt.ctrl.reg_idxw;
    ctrl_warpid_i   = bt.ctrl.warpid;
    in_valid_i      = v;
  endtask

  function automatic exp_t out_now();
    exp_t o;
    o.res  = result_o;
    o.ff   = fflags_o;
    o.ctrl = {ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o};
    return o;
  endfunction

  // One clock: observe handshakes just before the edge, then advance to the
  // next negedge where inputs are changed.
  task automatic cycle();
    exp_t e, o;
    #1;
    if (!rst) begin
      if (out_valid_o && out_ready_i) begin
        o = out_now();
        emit_n++; emit_cyc = cyc;
        last_res = o.res; last_ff = o.ff; last_ctrl = o.ctrl;
        emitted_c.push_back(int'(o.ctrl.c));
        check("sb_beat_expected", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_beat", 128'(o), 128'(e));
        end
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back(model(cur));
        acc_n++; acc_cyc = cyc;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_one(input beat_t bt);
    int a0, e0, n;
    a0 = acc_n; e0 = emit_n; n = 0;
    out_ready_i = 1'b1;
    set_in(bt, 1'b1);
    while (acc_n == a0 && n < 10) begin cycle(); n++; end
    in_valid_i = 1'b0;
    n = 0;
    while (emit_n == e0 && n < 10) begin cycle(); n++; end
    check("send_emitted", 128'(emit_n - e0), 128'(1));
    check("latency", 128'(emit_cyc - acc_cyc), 128'(PS));
  endtask

  initial begin
    beat_t bt;
    exp_t  held;
    bit    have_held;
    int    nc, n, en0;

    rst = 1'b1; out_ready_i = 1'b0;
    set_in(zero_beat(), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid_o), 128'(0));
    check("rst_result",    128'(result_o),    128'(0));
    check("rst_fflags",    128'(fflags_o),    128'(0));
    check("rst_ctrl",      128'({ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o}), 128'(0));
    check("rst_in_ready",  128'(in_ready_o),  128'(1));
    @(negedge clk);

    // Basic product
    bt = zero_beat(); bt.a[0] = 9'd10; bt.b[0] = 9'd20;
    bt.ctrl.warpid = 4'd5; bt.ctrl.c = 16'h0abc;
    send_one(bt);
    check("basic_lane0", 128'(last_res[EW-1:0]), 128'(200));
    check("basic_ff",    128'(last_ff), 128'(0));
    check("basic_warp",  128'(last_ctrl.warpid), 128'(5));

    // Overflow: wrap then saturate
    bt = zero_beat(); bt.a[0] = 9'd20; bt.b[0] = 9'd20;
    send_one(bt);
    check("wrap_lane0", 128'(last_res[EW-1:0]), 128'(9'h190));
    check("wrap_ff",    128'(last_ff), 128'(5'b00101));
    bt.rm = 3'd1;
    send_one(bt);
    check("sat_lane0", 128'(last_res[EW-1:0]), 128'(255));
    check("sat_ff",    128'(last_ff), 128'(5'b00101));

    // Negative saturation and exact minimum
    bt = zero_beat(); bt.rm = 3'd1; bt.a[0] = 9'h100; bt.b[0] = 9'h1ff;
    send_one(bt);
    check("negsat_lane0", 128'(last_res[EW-1:0]), 128'(255));
    check("negsat_ff",    128'(last_ff), 128'(5'b00101));
    bt.a[0] = 9'h1f0; bt.b[0] = 9'd16;
    send_one(bt);
    check("min_lane0", 128'(last_res[EW-1:0]), 128'(9'h100));
    check("min_ff",    128'(last_ff), 128'(0));

    // Masked overflowing lane
    bt = zero_beat(); bt.a[1] = 9'd3; bt.b[1] = 9'd4;
    bt.a[3] = 9'd100; bt.b[3] = 9'd100; bt.mask = 8'hf7;
    send_one(bt);
    check("mask_lane3", 128'(last_res[3*EW +: EW]), 128'(0));
    check("mask_lane1", 128'(last_res[1*EW +: EW]), 128'(12));
    check("mask_ff",    128'(last_ff), 128'(0));

    // Backpressure: 6 beats, consumer stalled for 5 cycles
    emitted_c.delete();
    out_ready_i = 1'b0; nc = 1; have_held = 0;
    for (int k = 0; k < 5; k++) begin
      bt = rand_beat(); bt.ctrl.c = 16'(nc);
      set_in(bt, 1'b1);
      en0 = acc_n;
      cycle();
      if (acc_n != en0) nc++;
      if (out_valid_o) begin
        if (!have_held) begin held = out_now(); have_held = 1; end
        else check("stall_stable", 128'(out_now()), 128'(held));
      end
    end
    #1;
    check("bp_accepted", 128'(nc - 1), 128'(PS));
    check("bp_in_ready", 128'(in_ready_o), 128'(0));
    @(negedge clk);
    out_ready_i = 1'b1;
    n = 0;
    while (nc <= 6 && n < 40) begin
      bt = rand_beat(); bt.ctrl.c = 16'(nc);
      set_in(bt, 1'b1);
      en0 = acc_n;
      cycle();
      if (acc_n != en0) nc++;
      n++;
    end
    in_valid_i = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin cycle(); n++; end
    check("bp_count", 128'(emitted_c.size()), 128'(6));
    for (int k = 0; k < emitted_c.size() && k < 6; k++)
      check("bp_order", 128'(emitted_c[k]), 128'(k + 1));

    // Reset with two beats in flight
    out_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin set_in(rand_beat(), 1'b1); cycle(); end
    in_valid_i = 1'b0;
    #1;
    check("pre_rst_valid", 128'(out_valid_o), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid",    128'(out_valid_o), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready_o),  128'(1));
    @(negedge clk);
    out_ready_i = 1'b1;
    en0 = emit_n;
    repeat (4) cycle();
    check("mid_rst_no_stale", 128'(emit_n), 128'(en0));

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      set_in(rand_beat(), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      out_ready_i = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      cycle();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin cycle(); n++; end
    check("rand_drained", 128'(q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tc_mul_array.md
Name: tc_mul_array

Overview:
- Parametrised successor to the tensor-core lane multiplier top: NUM_LANES signed integer multipliers behind one shared valid/ready handshake.
- PIPE_STAGES-deep pipeline with per-stage bubble collapsing.
- Per-lane mask and selectable wrap/saturate rounding.
- Control sideband (ctrl_*) travels through the pipeline registered and aligned with its data, not passed through combinationally.
- Sits between operand collection and the tensor-core accumulator.

Parameters:
- NUM_LANES, 8, number of multiplier lanes.
- ELEMENT_WIDTH, 9, signed two's-complement operand and result width per lane.
- PIPE_STAGES, 2, pipeline register stages. Must be ≥1; latency in cycles.
- CTRL_C_WIDTH, 16, width of the ctrl_c sideband.
- DEPTH_WARP, 4, width of the warp id sideband.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- a_i  in  NUM_LANES*ELEMENT_WIDTH  operand A; lane i at bits [(i+1)*EW-1 -: EW].
- b_i  in  NUM_LANES*ELEMENT_WIDTH  operand B; same packing.
- lane_mask_i  in  NUM_LANES  1 = lane active.
- rm_i  in  3  3'd0 = wrap (truncate), 3'd1 = saturate; other codes behave as wrap.
- ctrl_c_i  in  CTRL_C_WIDTH  sideband.
- ctrl_rm_i  in  3  sideband.
- ctrl_reg_idxw_i  in  8  sideband.
- ctrl_warpid_i  in  DEPTH_WARP  sideband.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer ready.
- result_o  out  NUM_LANES*ELEMENT_WIDTH  per-lane products.
- fflags_o  out  5  OR over active lanes: {NV,DZ,OF,UF,NX}.
- ctrl_c_o  out  CTRL_C_WIDTH  sideband aligned with result_o.
- ctrl_rm_o  out  3  sideband aligned with result_o.
- ctrl_reg_idxw_o  out  8  sideband aligned with result_o.
- ctrl_warpid_o  out  DEPTH_WARP  sideband aligned with result_o.

Behaviour:
- Reset: all stage valid bits cleared. out_valid_o=0, result_o=0, fflags_o=0, all ctrl_*_o=0.
  - in_ready_o=1 in the first cycle after rst deasserts.
  - rst mid-operation discards every in-flight beat; no partial output is produced.
- Pipeline: stage s holds valid v[s], payload, and sideband.
  - Last stage advances when out_ready_i.
  - Stage s loads from stage s-1 when !v[s] || advance[s].
  - in_ready_o = !v[0] || advance[0]. It is combinational from out_ready_i through the chain.
- Bubble collapsing: an empty stage accepts even while later stages stall. Up to PIPE_STAGES beats buffer with out_ready_i=0.
- Latency: PIPE_STAGES cycles from accept to out_valid_o when unstalled. Throughput 1 beat/cycle.
- Output stability: while out_valid_o && !out_ready_i, result_o, fflags_o and ctrl_*_o hold stable.
- Arithmetic (computed in stage 0 from inputs; later stages are pure registers):
  - Full product p = a*b, signed, 2*EW bits.
  - Wrap: result = p[EW-1:0]. OF and NX set if p is out of range [-2^(EW-1), 2^(EW-1)-1].
  - Saturate: out-of-range p clamps to max or min. OF and NX set.
  - NV, DZ and UF are always 0.
- Masked lanes (lane_mask_i[i]=0): result lane = 0, contribute no flags.
- Simultaneous accept and emit in the same cycle with a full pipeline is legal and sustains 1 beat/cycle.
- in_valid_i may drop without a handshake; no beat is captured.
- When v[last]=0, result_o and ctrl_*_o are don't-care. The bench checks them only with out_valid_o.

Decomposition:
- Package tc_mul_pkg:
  - RM_WRAP=3'd0, RM_SAT=3'd1.
  - fflag bit indices FF_NX=0, FF_UF=1, FF_OF=2, FF_DZ=3, FF_NV=4.
  - Packed sideband struct ctrl_t {c, rm, reg_idxw, warpid}.
- Sub-module tc_mul_lane: combinational multiply, range check, wrap/saturate, mask, per-lane flags. Instantiated NUM_LANES times.
- The top holds the generate loop, flag OR-reduction, and the PIPE_STAGES register/valid chain.

Test Plan:
- Basic product: lane0 a=10, b=20, rm=0, mask all ones, out_ready=1 → after PIPE_STAGES cycles lane0=200, fflags=0, ctrl_warpid_o equals input warpid.
- Overflow, wrap vs saturate: a=20, b=20.
  - rm=0 → lane=9'h190 (-112), fflags=5'b00101.
  - rm=1 → lane=255, fflags=5'b00101.
- Negative saturation and edge: a=-256, b=-1, rm=1 → lane=255 with OF|NX. a=-16, b=16, rm=1 → -256, flags=0.
- Mask: lane3 operands overflow, lane_mask_i[3]=0 → lane3=0, fflags=0, other lanes normal.
- Backpressure: stream 6 beats with ascending ctrl_c 1..6, out_ready_i=0 for 5 cycles.
  - in_ready_o drops after PIPE_STAGES beats accepted.
  - On release, outputs come in order 1..6, none lost or duplicated, outputs stable while stalled.
- Reset mid-flight: 2 beats in pipeline, assert rst one cycle → out_valid_o=0 next cycle, no stale beat appears after rst deasserts, in_ready_o=1.
